// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline front end: machine word, fetch FSM states, PC increment.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FETCH, HOLD, HALTED} fetch_state_t;
  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble (zero, invalid) beats load; neither keeps the current contents.
module if_id_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  load,
  input  logic  bubble,
  input  word_t ld_instr,
  input  word_t ld_pc,
  input  word_t ld_npc,
  output word_t instr,
  output word_t pc,
  output word_t npc,
  output logic  valid
);

  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      instr <= '0;
      pc    <= '0;
      npc   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= ld_instr;
      pc    <= ld_pc;
      npc   <= ld_npc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry skid buffer for a hit taken while held.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt / stall_cnt output ports.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  stall,
  input  logic  flush_if,
  input  logic  pipe_en,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output word_t imemload_id,
  output word_t pc_id,
  output word_t npc_id,
  output logic  valid_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t fetch_cnt,
  output word_t stall_cnt
`endif
);

  fetch_state_t state, state_next;
  word_t        pc_p0, pc_next;
  word_t        hold_buf_p0;
  logic         hold, buf_we, ld, bub;
  word_t        ld_instr, ld_pc, ld_npc;

  assign hold  = stall | ~pipe_en;
  assign iREN  = (state == FETCH);
  assign iaddr = pc_p0;

  // Priority: halt, then redirect, then per-state fetch/hold/flush handling.
  always_comb begin
    state_next = state;
    pc_next    = pc_p0;
    buf_we     = 1'b0;
    ld         = 1'b0;
    bub        = 1'b0;
    ld_instr   = iload;
    ld_pc      = pc_p0;
    ld_npc     = pc_p0 + PC_STEP;
    if (halt) begin
      state_next = HALTED;
      bub        = 1'b1;
    end else if (state == HALTED) begin
      bub = 1'b1;
    end else if (redirect) begin
      state_next = FETCH;
      pc_next    = redirect_pc & ~32'd3;
      bub        = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (!hold && flush_if) begin
            bub = 1'b1;
          end else if (ihit && !hold) begin
            ld      = 1'b1;
            pc_next = pc_p0 + PC_STEP;
          end else if (ihit) begin
            buf_we     = 1'b1;
            pc_next    = pc_p0 + PC_STEP;
            state_next = HOLD;
          end else if (!hold) begin
            bub = 1'b1;
          end
        end
        HOLD: begin
          if (!hold) begin
            state_next = FETCH;
            if (flush_if) begin
              bub     = 1'b1;
              pc_next = pc_p0 - PC_STEP;
            end else begin
              ld       = 1'b1;
              ld_instr = hold_buf_p0;
              ld_pc    = pc_p0 - PC_STEP;
              ld_npc   = pc_p0;
            end
          end
        end
        default: bub = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      pc_p0 <= PC_INIT;
    end else begin
      state <= state_next;
      pc_p0 <= pc_next;
    end
  end

  // Skid buffer holds data only; its occupancy is implied by state == HOLD.
  always_ff @(posedge CLK) begin
    if (buf_we) hold_buf_p0 <= iload;
  end

  if_id_reg u_if_id (
    .CLK      (CLK),
    .RST      (RST),
    .load     (ld),
    .bubble   (bub),
    .ld_instr (ld_instr),
    .ld_pc    (ld_pc),
    .ld_npc   (ld_npc),
    .instr    (imemload_id),
    .pc       (pc_id),
    .npc      (npc_id),
    .valid    (valid_id)
  );

`ifdef FETCH_PERF_CNT_EN
  function automatic word_t sat_inc(input word_t v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ld) fetch_cnt <= sat_inc(fetch_cnt);
      if (state == HOLD || (state == FETCH && hold)) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table on a PC_INIT=0 instance, plus a wrap-around instance.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic word_t word_of(input word_t a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Instance A: PC_INIT = 0
  logic  rst_a, ihit_a, stall_a, flush_a, pen_a, redir_a, halt_a, iren_a, valid_a;
  word_t iload_a, iaddr_a, rpc_a, imem_a, pcid_a, npc_a;
  assign iload_a = word_of(iaddr_a);

  // Instance B: PC_INIT at top of address space
  logic  rst_b, ihit_b, stall_b, flush_b, pen_b, redir_b, halt_b, iren_b, valid_b;
  word_t iload_b, iaddr_b, rpc_b, imem_b, pcid_b, npc_b;
  assign iload_b = word_of(iaddr_b);

`ifdef FETCH_PERF_CNT_EN
  word_t fcnt_a, scnt_a, fcnt_b, scnt_b;
`endif

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut_a (
    .CLK(CLK), .RST(rst_a), .ihit(ihit_a), .iload(iload_a), .iREN(iren_a), .iaddr(iaddr_a),
    .stall(stall_a), .flush_if(flush_a), .pipe_en(pen_a), .redirect(redir_a),
    .redirect_pc(rpc_a), .halt(halt_a), .imemload_id(imem_a), .pc_id(pcid_a),
    .npc_id(npc_a), .valid_id(valid_a)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fcnt_a), .stall_cnt(scnt_a)
`endif
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_b (
    .CLK(CLK), .RST(rst_b), .ihit(ihit_b), .iload(iload_b), .iREN(iren_b), .iaddr(iaddr_b),
    .stall(stall_b), .flush_if(flush_b), .pipe_en(pen_b), .redirect(redir_b),
    .redirect_pc(rpc_b), .halt(halt_b), .imemload_id(imem_b), .pc_id(pcid_b),
    .npc_id(npc_b), .valid_id(valid_b)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fcnt_b), .stall_cnt(scnt_b)
`endif
  );

  typedef struct {
    logic  rst, ihit, stall, flush, pen, redir;
    word_t rpc;
    logic  halt;
    logic  e_iren;
    word_t e_iaddr;
    word_t e_pc;
    logic  e_v;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, ihit, stall, flush, pen, redir, input word_t rpc,
                     input logic halt, input logic e_iren, input word_t e_iaddr, e_pc,
                     input logic e_v);
    vec_t v;
    v.rst = rst; v.ihit = ihit; v.stall = stall; v.flush = flush; v.pen = pen;
    v.redir = redir; v.rpc = rpc; v.halt = halt;
    v.e_iren = e_iren; v.e_iaddr = e_iaddr; v.e_pc = e_pc; v.e_v = e_v;
    vecs.push_back(v);
  endtask

  task automatic check_word(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    word_t e_imem, e_npc;
    {rst_a, ihit_a, stall_a, flush_a, redir_a, halt_a} = '0;
    pen_a = 1'b1; rpc_a = '0;
    {ihit_b, stall_b, flush_b, redir_b, halt_b} = '0;
    rst_b = 1'b1; pen_b = 1'b1; rpc_b = '0;

    //   rst ihit stl fls pen rdr rpc          hlt | iren iaddr        pc_id         v
    add(1, 0, 0, 0, 1, 0, 32'h0,        0,   1, 32'h00, 32'h00, 0);  // reset
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   1, 32'h04, 32'h00, 1);  // stream
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   1, 32'h08, 32'h04, 1);
    add(0, 1, 1, 0, 1, 0, 32'h0,        0,   0, 32'h0C, 32'h04, 1);  // hit while stalled
    add(0, 1, 1, 0, 1, 0, 32'h0,        0,   0, 32'h0C, 32'h04, 1);
    add(0, 0, 1, 0, 1, 0, 32'h0,        0,   0, 32'h0C, 32'h04, 1);
    add(0, 0, 0, 0, 1, 0, 32'h0,        0,   1, 32'h0C, 32'h08, 1);  // skid drains
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   1, 32'h10, 32'h0C, 1);
    add(0, 1, 1, 0, 1, 0, 32'h0,        0,   0, 32'h14, 32'h0C, 1);
    add(0, 1, 1, 0, 1, 1, 32'h43,       0,   1, 32'h40, 32'h00, 0);  // redirect in HOLD
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   1, 32'h44, 32'h40, 1);
    add(0, 0, 0, 0, 1, 1, 32'h10,       0,   1, 32'h10, 32'h00, 0);
    add(0, 1, 0, 1, 1, 0, 32'h0,        0,   1, 32'h10, 32'h00, 0);  // flush at 0x10
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   1, 32'h14, 32'h10, 1);
    add(0, 1, 0, 0, 0, 0, 32'h0,        0,   0, 32'h18, 32'h10, 1);  // pipe_en low
    add(0, 0, 0, 1, 1, 0, 32'h0,        0,   1, 32'h14, 32'h00, 0);  // flush drops skid
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   1, 32'h18, 32'h14, 1);
    add(0, 1, 0, 0, 1, 1, 32'h80,       1,   0, 32'h18, 32'h00, 0);  // halt beats redirect
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   0, 32'h18, 32'h00, 0);
    add(0, 0, 0, 0, 1, 1, 32'h80,       0,   0, 32'h18, 32'h00, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,        0,   1, 32'h00, 32'h00, 0);  // reset out of HALTED
    add(0, 1, 0, 0, 1, 0, 32'h0,        0,   1, 32'h04, 32'h00, 1);
    add(0, 0, 1, 0, 1, 0, 32'h0,        0,   1, 32'h04, 32'h00, 1);  // miss while held
    add(0, 1, 1, 0, 1, 0, 32'h0,        0,   0, 32'h08, 32'h00, 1);
    add(1, 0, 1, 0, 1, 0, 32'h0,        0,   1, 32'h00, 32'h00, 0);  // reset out of HOLD

    foreach (vecs[i]) begin
      @(negedge CLK);
      rst_a = vecs[i].rst; ihit_a = vecs[i].ihit; stall_a = vecs[i].stall;
      flush_a = vecs[i].flush; pen_a = vecs[i].pen; redir_a = vecs[i].redir;
      rpc_a = vecs[i].rpc; halt_a = vecs[i].halt;
      @(posedge CLK);
      #1;
      e_imem = vecs[i].e_v ? word_of(vecs[i].e_pc) : 32'h0;
      e_npc  = vecs[i].e_v ? vecs[i].e_pc + 32'd4 : 32'h0;
      checks++;
      if (iren_a !== vecs[i].e_iren || iaddr_a !== vecs[i].e_iaddr ||
          imem_a !== e_imem || pcid_a !== vecs[i].e_pc || npc_a !== e_npc ||
          valid_a !== vecs[i].e_v) begin
        errors++;
        $display("FAIL vec%0d: got iREN=%b iaddr=%h instr=%h pc=%h npc=%h v=%b expected iREN=%b iaddr=%h instr=%h pc=%h npc=%h v=%b",
                 i, iren_a, iaddr_a, imem_a, pcid_a, npc_a, valid_a,
                 vecs[i].e_iren, vecs[i].e_iaddr, e_imem, vecs[i].e_pc, e_npc, vecs[i].e_v);
      end
    end

    // PC wrap: instance B has been in reset throughout the table.
    @(negedge CLK);
    check_word("wrap_reset_iaddr", iaddr_b, 32'hFFFF_FFFC);
    check_word("wrap_reset_iren", {31'd0, iren_b}, 32'd1);
    rst_b = 1'b0; ihit_b = 1'b1;
    @(posedge CLK);
    #1;
    check_word("wrap_iaddr", iaddr_b, 32'h0000_0000);
    check_word("wrap_pc_id", pcid_b, 32'hFFFF_FFFC);
    check_word("wrap_npc_id", npc_b, 32'h0000_0000);
    check_word("wrap_instr", imem_b, word_of(32'hFFFF_FFFC));
    check_word("wrap_valid", {31'd0, valid_b}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check_word("wrap_fetch_cnt", fcnt_b, 32'd1);
    check_word("wrap_stall_cnt", scnt_b, 32'd0);
`endif
    @(negedge CLK);
    stall_b = 1'b1;
    @(posedge CLK);
    #1;
    check_word("wrap_hold_iren", {31'd0, iren_b}, 32'd0);
    check_word("wrap_hold_iaddr", iaddr_b, 32'h0000_0004);
`ifdef FETCH_PERF_CNT_EN
    check_word("hold_stall_cnt", scnt_b, 32'd1);
    check_word("hold_fetch_cnt", fcnt_b, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
